hough_accumulator: RTL and testbench

//  Vote memory directly downstream of FSMHough: consumes its (write_enable, address=rho, theta) vote stream, and

---
 rtl/hough_accumulator_pkg.sv | 24 ++
 rtl/hough_acc_ram.sv | 30 +++
 rtl/hough_accumulator.sv | 224 ++++++++++++++++++++++
 tb/tb_hough_accumulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hough_accumulator_pkg.sv
// Shared definitions for the Hough vote accumulator: parameter defaults,
// FSM state encoding and the bin-depth helper used to size the vote memory.
// Imported by the accumulator top and its RAM.
package hough_accumulator_pkg;

  localparam int RHO_W_DEF     = 11;
  localparam int THETA_W_DEF   = 8;
  localparam int NUM_THETA_DEF = 180;
  localparam int CNT_W_DEF     = 10;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } hough_state_e;

  // Number of vote bins: every valid theta owns a full row of 2**rho_w bins.
  function automatic int bin_depth(input int num_theta, input int rho_w);
    return num_theta * (1 << rho_w);
  endfunction

endpackage

// File: rtl/hough_acc_ram.sv
// Vote memory: one write port, one synchronous read port, no content reset.
// Read latency 1 cycle; read of an address written in the same cycle is undefined.
// No backpressure; both ports accept one access every cycle.
module hough_acc_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 4
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdat;

  // Contents are initialised by the owner's clear pass, so no reset here.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
    r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/hough_accumulator.sv
// Hough vote accumulator: counts (theta,rho) votes per frame, then scans for the peak and clears.
// Vote-to-RAM-write latency 2 cycles; peak reported D+4 cycles after frame_done.
// No backpressure: votes arriving outside ACCUM or with theta out of range are dropped and flagged.
module hough_accumulator
  import hough_accumulator_pkg::*;
#(
  parameter int RHO_W     = RHO_W_DEF,
  parameter int THETA_W   = THETA_W_DEF,
  parameter int NUM_THETA = NUM_THETA_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_write_enable,
  input  logic [RHO_W-1:0]   i_address,
  input  logic [THETA_W-1:0] i_theta,
  input  logic               i_frame_done,
  output logic               o_accum_ready,
  output logic               o_peak_valid,
  output logic [RHO_W-1:0]   o_peak_rho,
  output logic [THETA_W-1:0] o_peak_theta,
  output logic [CNT_W-1:0]   o_peak_votes,
  output logic               o_sat_flag,
  output logic               o_drop_flag
);

  localparam int D    = bin_depth(NUM_THETA, RHO_W);
  localparam int AW   = $clog2(D);
  localparam int TI_W = AW - RHO_W;
  localparam int CW   = $clog2(D + 2);

  localparam logic [CW-1:0]      CNT_ONE        = CW'(1);
  localparam logic [CW-1:0]      CNT_CLR_LAST   = CW'(D - 1);
  localparam logic [CW-1:0]      CNT_DRAIN_LAST = CW'(1);
  localparam logic [CW-1:0]      CNT_SCAN_RD    = CW'(D);
  localparam logic [CW-1:0]      CNT_SCAN_LAST  = CW'(D + 1);
  localparam logic [THETA_W-1:0] THETA_LIM      = THETA_W'(NUM_THETA);
  localparam logic [CNT_W-1:0]   VOTE_MAX       = '1;
  localparam logic [CNT_W-1:0]   VOTE_ONE       = CNT_W'(1);

  hough_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;

  // Vote intake
  logic          w_vote_acc, w_vote_drop;
  logic [AW-1:0] w_vote_idx;

  // RMW pipeline: S1 = read data returning, S2 = write in flight, S3 = last completed write
  logic             r_s1_vld, r_s2_vld, r_s3_vld;
  logic [AW-1:0]    r_s1_idx, r_s2_idx, r_s3_idx;
  logic [CNT_W-1:0] r_s2_dat, r_s3_dat;
  logic [CNT_W-1:0] w_base, w_inc;

  // Scan / max tracker
  logic             r_scan_vld;
  logic [AW-1:0]    r_scan_idx;
  logic [AW-1:0]    r_max_idx;
  logic [CNT_W-1:0] r_max_votes;

  // RAM ports
  logic             w_ram_we;
  logic [AW-1:0]    w_ram_waddr, w_ram_raddr;
  logic [CNT_W-1:0] w_ram_wdat, w_ram_rdat;

  logic w_enter_accum, w_enter_scan, w_enter_done;

  // State register; reset always restarts the clear pass.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_CLEAR;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_nxt   = r_state;
    o_accum_ready = 1'b0;
    o_peak_valid  = 1'b0;
    case (r_state)
      ST_CLEAR: if (r_cnt == CNT_CLR_LAST) w_state_nxt = ST_ACCUM;
      ST_ACCUM: begin
        o_accum_ready = 1'b1;
        if (i_frame_done) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (r_cnt == CNT_DRAIN_LAST) w_state_nxt = ST_SCAN;
      ST_SCAN:  if (r_cnt == CNT_SCAN_LAST) w_state_nxt = ST_DONE;
      ST_DONE: begin
        o_peak_valid = 1'b1;
        w_state_nxt  = ST_ACCUM;
      end
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign w_enter_accum = (w_state_nxt == ST_ACCUM) && (r_state != ST_ACCUM);
  assign w_enter_scan  = (w_state_nxt == ST_SCAN)  && (r_state != ST_SCAN);
  assign w_enter_done  = (w_state_nxt == ST_DONE)  && (r_state != ST_DONE);

  // Per-state cycle counter, restarted on every state change (idle in ACCUM).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                            r_cnt <= '0;
    else if ((w_state_nxt != r_state) || (r_state == ST_ACCUM)) r_cnt <= '0;
    else                                                    r_cnt <= r_cnt + CNT_ONE;
  end

  // Bin index is theta concatenated above rho; range check guards the aliasing.
  assign w_vote_idx  = {i_theta[TI_W-1:0], i_address};
  assign w_vote_acc  = i_write_enable && (r_state == ST_ACCUM) && (i_theta < THETA_LIM);
  assign w_vote_drop = i_write_enable && !w_vote_acc;

  // Forward the newest in-flight value of the same bin: S2 has not reached the RAM
  // yet, and S3 was written in the very cycle S1's read was issued.
  always_comb begin
    w_base = w_ram_rdat;
    if (r_s2_vld && (r_s2_idx == r_s1_idx))      w_base = r_s2_dat;
    else if (r_s3_vld && (r_s3_idx == r_s1_idx)) w_base = r_s3_dat;
    w_inc = (w_base == VOTE_MAX) ? VOTE_MAX : (w_base + VOTE_ONE);
  end

  // Read-modify-write pipeline stages.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_s1_vld <= 1'b0; r_s1_idx <= '0;
      r_s2_vld <= 1'b0; r_s2_idx <= '0; r_s2_dat <= '0;
      r_s3_vld <= 1'b0; r_s3_idx <= '0; r_s3_dat <= '0;
    end else begin
      r_s1_vld <= w_vote_acc;
      r_s1_idx <= w_vote_idx;
      r_s2_vld <= r_s1_vld;
      r_s2_idx <= r_s1_idx;
      r_s2_dat <= w_inc;
      r_s3_vld <= r_s2_vld;
      r_s3_idx <= r_s2_idx;
      r_s3_dat <= r_s2_dat;
    end
  end

  // Sticky frame flags, cleared whenever a new accumulation period begins.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_sat_flag  <= 1'b0;
      o_drop_flag <= 1'b0;
    end else if (w_enter_accum) begin
      o_sat_flag  <= 1'b0;
      o_drop_flag <= 1'b0;
    end else begin
      if (r_s1_vld && (w_inc == VOTE_MAX)) o_sat_flag  <= 1'b1;
      if (w_vote_drop)                     o_drop_flag <= 1'b1;
    end
  end

  // Scan read tracking: the bin read at count k returns (and is cleared) one cycle later.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_scan_vld <= 1'b0;
      r_scan_idx <= '0;
    end else begin
      r_scan_vld <= (r_state == ST_SCAN) && (r_cnt < CNT_SCAN_RD);
      r_scan_idx <= r_cnt[AW-1:0];
    end
  end

  // Running maximum; strict compare keeps the lowest index on ties.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_max_idx   <= '0;
      r_max_votes <= '0;
    end else if (w_enter_scan) begin
      r_max_idx   <= '0;
      r_max_votes <= '0;
    end else if (r_scan_vld && (w_ram_rdat > r_max_votes)) begin
      r_max_idx   <= r_scan_idx;
      r_max_votes <= w_ram_rdat;
    end
  end

  // Peak outputs captured once per frame and held until the next report.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_peak_rho   <= '0;
      o_peak_theta <= '0;
      o_peak_votes <= '0;
    end else if (w_enter_done) begin
      o_peak_rho   <= r_max_idx[RHO_W-1:0];
      o_peak_theta <= THETA_W'(r_max_idx[AW-1:RHO_W]);
      o_peak_votes <= r_max_votes;
    end
  end

  // RAM port steering: clear pass, scan-and-clear, or pipeline write-back.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_s2_idx;
    w_ram_wdat  = r_s2_dat;
    w_ram_raddr = w_vote_idx;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_cnt[AW-1:0];
        w_ram_wdat  = '0;
      end
      ST_SCAN: begin
        w_ram_we    = r_scan_vld;
        w_ram_waddr = r_scan_idx;
        w_ram_wdat  = '0;
        w_ram_raddr = r_cnt[AW-1:0];
      end
      default: w_ram_we = r_s2_vld;
    endcase
  end

  hough_acc_ram #(
    .DEPTH (D),
    .AW    (AW),
    .DW    (CNT_W)
  ) u_ram (
    .i_clock (i_clock),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdat  (w_ram_wdat),
    .i_raddr (w_ram_raddr),
    .o_rdat  (w_ram_rdat)
  );

endmodule

// File: tb/tb_hough_accumulator.sv
// Directed bench for hough_accumulator with a small 4x16 bin array.
// Expected peaks are queued when a frame is closed and compared when peak_valid pulses.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hough_accumulator;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_write_enable;
  logic [3:0] i_address;
  logic [7:0] i_theta;
  logic       i_frame_done;
  logic       o_accum_ready, o_peak_valid, o_sat_flag, o_drop_flag;
  logic [3:0] o_peak_rho;
  logic [7:0] o_peak_theta;
  logic [3:0] o_peak_votes;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  typedef struct {
    logic [3:0] rho;
    logic [7:0] theta;
    logic [3:0] votes;
    logic       sat;
    logic       drop;
  } exp_t;
  exp_t q[$];

  hough_accumulator #(
    .RHO_W     (4),
    .THETA_W   (8),
    .NUM_THETA (4),
    .CNT_W     (4)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_write_enable (i_write_enable),
    .i_address      (i_address),
    .i_theta        (i_theta),
    .i_frame_done   (i_frame_done),
    .o_accum_ready  (o_accum_ready),
    .o_peak_valid   (o_peak_valid),
    .o_peak_rho     (o_peak_rho),
    .o_peak_theta   (o_peak_theta),
    .o_peak_votes   (o_peak_votes),
    .o_sat_flag     (o_sat_flag),
    .o_drop_flag    (o_drop_flag)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic vote(input int t, input int r, input int n);
    i_write_enable = 1'b1;
    i_theta        = 8'(t);
    i_address      = 4'(r);
    repeat (n) tick();
    i_write_enable = 1'b0;
  endtask

  task automatic push_exp(input int r, input int t, input int v, input logic s, input logic d);
    exp_t e;
    e.rho = 4'(r); e.theta = 8'(t); e.votes = 4'(v); e.sat = s; e.drop = d;
    q.push_back(e);
  endtask

  task automatic frame_end();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b0;
  endtask

  task automatic wait_peak(input string tag);
    int start;
    int n;
    start = pulses;
    n = 0;
    while (pulses == start && n < 300) begin
      tick();
      n++;
    end
    chk(tag, pulses - start, 1);
  endtask

  // Counts cycles from reset release until accum_ready, checking outputs stay quiet.
  task automatic wait_ready(input string tag, input string tag_q);
    int   n;
    logic bad;
    n = 0;
    bad = 1'b0;
    do begin
      tick();
      n++;
      if (o_peak_valid !== 1'b0 || o_peak_votes !== 4'd0 || o_peak_rho !== 4'd0 ||
          o_peak_theta !== 8'd0 || o_sat_flag !== 1'b0 || o_drop_flag !== 1'b0) bad = 1'b1;
    end while (o_accum_ready !== 1'b1 && n < 200);
    chk(tag, n, 64);
    chk(tag_q, bad, 0);
  endtask

  // Scoreboard consumer: every peak_valid pulse must match the oldest queued frame.
  always @(negedge i_clock) begin
    if (o_peak_valid === 1'b1) begin
      exp_t e;
      pulses++;
      chk("sb_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("peak_rho",   o_peak_rho,   e.rho);
        chk("peak_theta", o_peak_theta, e.theta);
        chk("peak_votes", o_peak_votes, e.votes);
        chk("sat_flag",   o_sat_flag,   e.sat);
        chk("drop_flag",  o_drop_flag,  e.drop);
      end
    end
  end

  initial begin
    int p6;
    i_reset = 1'b1;
    i_write_enable = 1'b0;
    i_address = '0;
    i_theta = '0;
    i_frame_done = 1'b0;
    repeat (3) tick();

    // 1: reset state and clear-pass length
    chk("rst_ready", o_accum_ready, 0);
    chk("rst_peak_valid", o_peak_valid, 0);
    chk("rst_peak_votes", o_peak_votes, 0);
    chk("rst_flags", {o_sat_flag, o_drop_flag}, 0);
    i_reset = 1'b0;
    wait_ready("clear_cycles", "clear_outputs_quiet");

    // 2: consecutive same-bin votes; frame_done together with the last vote
    vote(1, 3, 5);
    i_write_enable = 1'b1; i_theta = 8'd2; i_address = 4'd7;
    tick();
    i_frame_done = 1'b1;
    push_exp(3, 1, 5, 1'b0, 1'b0);
    tick();
    i_write_enable = 1'b0; i_frame_done = 1'b0;
    wait_peak("peak_f2");
    chk("peak_valid_one_cycle", o_peak_valid, 0);
    chk("ready_after_done", o_accum_ready, 1);
    repeat (3) tick();
    chk("peak_votes_hold", o_peak_votes, 5);

    // 2b: empty frame after scan-and-clear
    push_exp(0, 0, 0, 1'b0, 1'b0);
    frame_end();
    wait_peak("peak_f2b");

    // 3: saturation
    vote(0, 0, 20);
    repeat (2) tick();
    chk("sat_during_accum", o_sat_flag, 1);
    push_exp(0, 0, 15, 1'b1, 1'b0);
    frame_end();
    wait_peak("peak_f3");
    chk("sat_cleared", o_sat_flag, 0);
    vote(2, 2, 1);
    push_exp(2, 2, 1, 1'b0, 1'b0);
    frame_end();
    wait_peak("peak_f3b");

    // 4: out-of-range theta (would alias onto bin (0,5), lower index than (1,1))
    vote(4, 5, 1);
    vote(1, 1, 1);
    tick();
    chk("drop_theta", o_drop_flag, 1);
    push_exp(1, 1, 1, 1'b0, 1'b1);
    frame_end();
    wait_peak("peak_f4");
    chk("drop_cleared", o_drop_flag, 0);

    // 4b: votes presented during SCAN are dropped
    push_exp(0, 0, 0, 1'b0, 1'b1);
    frame_end();
    repeat (5) tick();
    vote(0, 0, 5);
    wait_peak("peak_f4b");

    // 5: tie resolves to the lowest bin index
    vote(3, 1, 3);
    vote(0, 9, 3);
    push_exp(9, 0, 3, 1'b0, 1'b0);
    frame_end();
    wait_peak("peak_f5");

    // 6: reset in the middle of SCAN
    p6 = pulses;
    vote(3, 15, 4);
    frame_end();
    repeat (10) tick();
    i_reset = 1'b1;
    repeat (2) tick();
    chk("rst6_ready", o_accum_ready, 0);
    chk("rst6_peak_votes", o_peak_votes, 0);
    chk("rst6_peak_rho", o_peak_rho, 0);
    i_reset = 1'b0;
    wait_ready("clear6_cycles", "clear6_outputs_quiet");
    chk("rst6_no_peak", pulses, p6);

    // 7: memory fully cleared after reset recovery
    vote(2, 3, 1);
    push_exp(3, 2, 1, 1'b0, 1'b0);
    frame_end();
    wait_peak("peak_f7");

    repeat (3) tick();
    chk("sb_drained", q.size(), 0);
    chk("pulse_total", pulses, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
